ifu_fetch: RTL

Instruction fetch unit for the multi-cycle core. It consumes the one-hot stage vector from the stage sequencer and owns the program counter. During the IF stage it runs a single-outstanding request/response transaction to instruction memory. It asserts `hold` to keep the sequencer in IF until the instruction word is latched for ID.

---
 rtl/ifu_fetch_pkg.sv | 24 ++
 rtl/ifu_fetch_if.sv | 29 ++
 rtl/ifu_fetch_pc_reg.sv | 62 ++++++
 rtl/ifu_fetch.sv | 95 +++++++++
 4 files changed

// File: rtl/ifu_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit: stage vector
// encoding, fetch FSM states, reset PC and the NOP instruction word.
package ifu_fetch_pkg;

  localparam int STATE_W = 5;

  typedef logic [STATE_W-1:0] state_bus_t;

  localparam state_bus_t IF_STATE  = 5'b00001;
  localparam state_bus_t ID_STATE  = 5'b00010;
  localparam state_bus_t EX_STATE  = 5'b00100;
  localparam state_bus_t MEM_STATE = 5'b01000;
  localparam state_bus_t WB_STATE  = 5'b10000;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [31:0] RST_PC   = 32'h0000_0000;

  typedef enum logic [1:0] {
    FSM_IDLE = 2'd0,
    FSM_REQ  = 2'd1,
    FSM_WAIT = 2'd2
  } fetch_fsm_e;

endpackage

// File: rtl/ifu_fetch_if.sv
// Instruction-memory request/response bundle between the fetch unit
// (master) and instruction memory (slave).
interface ifu_fetch_if #(
  parameter int ADDR_W = 32
) ();

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              rsp_valid;
  logic [31:0]       rsp_data;

  modport master (
    output req_valid,
    output req_addr,
    input  req_ready,
    input  rsp_valid,
    input  rsp_data
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    output req_ready,
    output rsp_valid,
    output rsp_data
  );

endinterface

// File: rtl/ifu_fetch_pc_reg.sv
// Program counter with a pending redirect target. The pc only moves on the
// WB edge: to the (word-aligned) redirect target if one is pending, else pc+4.
module pc_reg
  import ifu_fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RST_PC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_i,
  input  logic              jump_en_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  output logic [ADDR_W-1:0] pc_o
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] tgt_q, tgt_d;
  logic              pend_q, pend_d;

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:2], 2'b00};
  endfunction

  // A redirect arriving on the WB edge itself bypasses the pending register.
  always_comb begin
    pc_d   = pc_q;
    tgt_d  = tgt_q;
    pend_d = pend_q;
    if (wb_i) begin
      pend_d = 1'b0;
      if (jump_en_i) begin
        pc_d = word_align(jump_addr_i);
      end else if (pend_q) begin
        pc_d = word_align(tgt_q);
      end else begin
        pc_d = pc_q + ADDR_W'(4);
      end
    end else if (jump_en_i) begin
      pend_d = 1'b1;
      tgt_d  = jump_addr_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= RESET_PC;
      pend_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      pend_q <= pend_d;
    end
  end

  // The target is only meaningful while pend_q is set, so it carries no reset.
  always_ff @(posedge clk) begin
    tgt_q <= tgt_d;
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: runs one request/response to instruction memory
// per IF stage, latches the word for ID, and holds the sequencer until then.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RST_PC)
) (
  input  logic              clk,
  input  logic              rst,
  input  state_bus_t        state,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic              hold,
  ifu_fetch_if.master       imem,
  output logic [ADDR_W-1:0] pc,
  output logic [31:0]       inst,
  output logic              inst_valid
);

  fetch_fsm_e  fsm_q, fsm_d;
  logic [31:0] inst_q, inst_d;
  logic        inst_valid_q, inst_valid_d;
  logic        req_valid;
  logic        rsp_take;
  logic        is_if;

  assign is_if = (state == IF_STATE);

  pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk         (clk),
    .rst         (rst),
    .wb_i        (state == WB_STATE),
    .jump_en_i   (jump_en),
    .jump_addr_i (jump_addr),
    .pc_o        (pc)
  );

  always_comb begin
    fsm_d        = fsm_q;
    inst_d       = inst_q;
    inst_valid_d = inst_valid_q;
    req_valid    = 1'b0;
    rsp_take     = 1'b0;
    unique case (fsm_q)
      FSM_IDLE: begin
        if (is_if) begin
          fsm_d        = FSM_REQ;
          inst_valid_d = 1'b0;
        end
      end
      FSM_REQ: begin
        req_valid = 1'b1;
        if (imem.req_ready) fsm_d = FSM_WAIT;
      end
      FSM_WAIT: begin
        // Responses outside WAIT are ignored; only this state consumes one.
        if (imem.rsp_valid) begin
          rsp_take     = 1'b1;
          inst_d       = imem.rsp_data;
          inst_valid_d = 1'b1;
          fsm_d        = FSM_IDLE;
        end
      end
      default: fsm_d = FSM_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q        <= FSM_IDLE;
      inst_q       <= NOP_INST;
      inst_valid_q <= 1'b0;
    end else begin
      fsm_q        <= fsm_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
    end
  end

  // Combinational release lets the sequencer leave IF on the latching edge.
  assign hold           = is_if & ~rsp_take;
  assign imem.req_valid = req_valid;
  assign imem.req_addr  = pc;
  assign inst           = inst_q;
  assign inst_valid     = inst_valid_q;

  a_if_while_busy : assert property (
    @(posedge clk) disable iff (rst) (fsm_q != FSM_IDLE) |-> (state == IF_STATE)
  );

endmodule
